// File: rtl/control_pkg.sv
// control_pkg: funct3 encodings for the M-extension divide ops and the divider state type.
package control_pkg;
  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on magnitudes.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   r_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN:0]   r_o,
  output logic [XLEN-1:0] q_o
);
  logic [XLEN:0] sh, d;
  logic unused_r;
  // the partial remainder stays below |b|, so its top bit is always shifted out as zero
  assign unused_r = r_i[XLEN];
  assign sh  = {r_i[XLEN-1:0], q_i[XLEN-1]};
  assign d   = sh - {1'b0, b_i};
  assign r_o = d[XLEN] ? sh : d;
  assign q_o = {q_i[XLEN-2:0], ~d[XLEN]};
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready on both sides.
module div_unit
  import control_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  localparam int CW = $clog2(XLEN + 1);
  div_state_t state_q, state_d;
  logic [1:0] f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, q_q, q_d, res_q, res_d, q_nx, a_abs, b_abs;
  logic [XLEN:0] r_q, r_d, r_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sgn, a_neg, b_neg, unused_f3;
  assign unused_f3 = funct3_i[2];
  assign sgn   = ~f3_q[0];
  assign a_neg = sgn & a_q[XLEN-1];
  assign b_neg = sgn & b_q[XLEN-1];
  assign a_abs = a_neg ? -a_q : a_q;
  assign b_abs = b_neg ? -b_q : b_q;
  div_step #(.XLEN(XLEN)) u_step (
    .r_i(r_q),
    .q_i(q_q),
    .b_i(b_abs),
    .r_o(r_nx),
    .q_o(q_nx)
  );
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (valid_i && !flush_i) begin
        state_d = PREP;
        f3_d    = funct3_i[1:0];
        a_d     = op_a_i;
        b_d     = op_b_i;
      end
      PREP: if (b_q == '0) begin
        res_d   = f3_q[1] ? a_q : '1;
        state_d = DONE;
      end else if (sgn && a_q == {1'b1, {(XLEN-1){1'b0}}} && b_q == '1) begin
        res_d   = f3_q[1] ? '0 : a_q;
        state_d = DONE;
      end else begin
        q_d     = a_abs;
        r_d     = '0;
        cnt_d   = CW'(XLEN);
        state_d = CALC;
      end
      CALC: begin
        q_d     = q_nx;
        r_d     = r_nx;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? FIX : CALC;
      end
      FIX: begin
        res_d   = f3_q[1] ? (a_neg ? -r_q[XLEN-1:0] : r_q[XLEN-1:0]) : ((a_neg ^ b_neg) ? -q_q : q_q);
        state_d = DONE;
      end
      DONE: state_d = ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end
  assign ready_o  = state_q == IDLE;
  assign busy_o   = state_q != IDLE;
  assign valid_o  = state_q == DONE;
  assign result_o = res_q;
endmodule
